pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 60 ++++++
 rtl/hazard_fwd_sel.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - forwarding operand-source encodings
//   - hazard FSM state encoding
//   - bit positions of the mispredict flag in pc_src and the load flag in
//     result_src
//   - the per-stage stall/flush control bundle and its canonical patterns
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_pkg;

    // Operand source selects driven to the Execute-stage bypass muxes.
    localparam logic [1:0] FWD_NONE = 2'b00;  // register-file value
    localparam logic [1:0] FWD_WB   = 2'b01;  // Writeback result
    localparam logic [1:0] FWD_MEM  = 2'b10;  // Memory-stage result

    // Hazard FSM. HOLD waits out a non-abortable I-cache refill before the
    // redirect is allowed to take effect; REDIRECT lasts exactly one cycle.
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_HOLD     = 2'b01,
        ST_REDIRECT = 2'b10
    } hz_state_t;

    // pc_src[1] set means a mispredict / redirect is requested.
    localparam int PC_SRC_MISPRED_BIT  = 1;
    // result_src[2] set means the Execute-stage instruction is a load.
    localparam int RESULT_SRC_LOAD_BIT = 2;

    // Load-use bubble counter width; covers LOAD_USE_STALL-1 for 1..3.
    localparam int LD_CNT_W = 2;

    // Per-stage control bundle, MSB first in the order declared.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic stall_w;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } hz_ctl_t;

    // Canonical control patterns, bit order {stall_f,d,e,m,w, flush_d,e,m}.
    localparam hz_ctl_t CTL_NONE      = 8'b00000_000;
    localparam hz_ctl_t CTL_ALL_STALL = 8'b11111_000;  // freeze everything
    localparam hz_ctl_t CTL_HOLD      = 8'b11111_100;  // freeze, kill Decode
    localparam hz_ctl_t CTL_REDIRECT  = 8'b01111_110;  // fetch new PC only
    localparam hz_ctl_t CTL_EX_BUSY   = 8'b11100_001;  // bubble into Memory
    localparam hz_ctl_t CTL_MISPRED   = 8'b00000_110;  // squash wrong path
    localparam hz_ctl_t CTL_LOAD_USE  = 8'b11000_010;  // bubble into Execute

    // True when the PC-select field requests a redirect.
    function automatic logic is_mispredict(input logic [1:0] pc_src);
        return pc_src[PC_SRC_MISPRED_BIT];
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// Single-operand forwarding select for the Execute stage. Register 0 is
// hard-wired to zero and is never forwarded; when both later stages write
// the same register the Memory stage holds the younger value and wins.
//
// Ports:
//   rs          in  REG_ADDR_W  source register of the Execute operand
//   rd_m        in  REG_ADDR_W  destination register in Memory
//   reg_write_m in  1           Memory stage writes rd_m
//   rd_w        in  REG_ADDR_W  destination register in Writeback
//   reg_write_w in  1           Writeback stage writes rd_w
//   fwd_sel     out 2           FWD_NONE / FWD_WB / FWD_MEM
// -----------------------------------------------------------------------------
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    output logic [1:0]            fwd_sel
);

    always_comb begin
        if (rs == '0) begin
            fwd_sel = FWD_NONE;
        end else if (reg_write_m && (rs == rd_m)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (rs == rd_w)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard unit for a five-stage in-order pipeline. Produces per-stage stall
// and flush (bubble) controls, Execute-stage operand forwarding selects, and
// sequences mispredict redirects around I-cache misses and refills.
//
// Event priority, highest first:
//   reset > D-cache miss > HOLD/REDIRECT > I-cache miss > Execute busy
//         > mispredict > load-use
//
// Ports:
//   clk_i                    in  1   clock, rising edge
//   reset_i                  in  1   synchronous active-high reset
//   instr_miss_f_i           in  1   I-cache miss on current fetch
//   instr_cache_rep_active_i in  1   I-cache line refill in progress
//   data_miss_m_i            in  1   D-cache miss in Memory
//   ex_busy_e_i              in  1   multicycle Execute op not finished
//   rs1_d_i, rs2_d_i         in  W   Decode source registers
//   rs1_e_i, rs2_e_i         in  W   Execute source registers
//   rd_e_i, rd_m_i, rd_w_i   in  W   Execute/Memory/Writeback destinations
//   result_src_e_i           in  3   Execute result select (bit 2 = load)
//   pc_src_i                 in  2   PC select (bit 1 = mispredict)
//   reg_write_m_i            in  1   Memory register-write enable
//   reg_write_w_i            in  1   Writeback register-write enable
//   stall_{f,d,e,m,w}_o      out 1   per-stage stall
//   flush_{d,e,m}_o          out 1   per-stage bubble
//   forward_a_e_o            out 2   operand A source
//   forward_b_e_o            out 2   operand B source
//   redirect_pending_o       out 1   FSM in HOLD or REDIRECT
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1   // bubbles per load-use hazard, 1..3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  instr_miss_f_i,
    input  logic                  instr_cache_rep_active_i,
    input  logic                  data_miss_m_i,
    input  logic                  ex_busy_e_i,
    input  logic [REG_ADDR_W-1:0] rs1_d_i,
    input  logic [REG_ADDR_W-1:0] rs2_d_i,
    input  logic [REG_ADDR_W-1:0] rs1_e_i,
    input  logic [REG_ADDR_W-1:0] rs2_e_i,
    input  logic [REG_ADDR_W-1:0] rd_e_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic [2:0]            result_src_e_i,
    input  logic [1:0]            pc_src_i,
    input  logic                  reg_write_m_i,
    input  logic                  reg_write_w_i,
    output logic                  stall_f_o,
    output logic                  stall_d_o,
    output logic                  stall_e_o,
    output logic                  stall_m_o,
    output logic                  stall_w_o,
    output logic                  flush_d_o,
    output logic                  flush_e_o,
    output logic                  flush_m_o,
    output logic [1:0]            forward_a_e_o,
    output logic [1:0]            forward_b_e_o,
    output logic                  redirect_pending_o
);

    // Value loaded on a fresh load-use hazard: the detect cycle itself is the
    // first bubble, the counter covers the remaining ones.
    localparam logic [LD_CNT_W-1:0] LD_CNT_INIT = LD_CNT_W'(LOAD_USE_STALL - 1);
    localparam logic [LD_CNT_W-1:0] LD_CNT_ONE  = LD_CNT_W'(1);

    hz_state_t             state_q, state_d;
    logic [LD_CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
    hz_ctl_t               ctl, ctl_out;
    logic                  mispredict;
    logic                  load_use;
    logic [1:0]            fwd_a, fwd_b;

    // Only the load bit of result_src and the redirect bit of pc_src carry
    // hazard information; the remaining bits are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{result_src_e_i[1:0], pc_src_i[0]};

    // -------------------------------------------------------------------------
    // Forwarding
    // -------------------------------------------------------------------------
    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs          (rs1_e_i),
        .rd_m        (rd_m_i),
        .reg_write_m (reg_write_m_i),
        .rd_w        (rd_w_i),
        .reg_write_w (reg_write_w_i),
        .fwd_sel     (fwd_a)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs          (rs2_e_i),
        .rd_m        (rd_m_i),
        .reg_write_m (reg_write_m_i),
        .rd_w        (rd_w_i),
        .reg_write_w (reg_write_w_i),
        .fwd_sel     (fwd_b)
    );

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    // A redirect is only honoured from RUN, and not while the Execute or
    // Memory stage is holding the pipeline: the branch outcome is not final.
    assign mispredict = (state_q == ST_RUN) && !ex_busy_e_i && !data_miss_m_i &&
                        is_mispredict(pc_src_i);

    assign load_use = result_src_e_i[RESULT_SRC_LOAD_BIT] && (rd_e_i != '0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

    // -------------------------------------------------------------------------
    // Control decode and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the priority chain so no
        // path leaves one unassigned, which would infer a latch.
        ctl      = CTL_NONE;
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;

        if (data_miss_m_i) begin
            // Whole pipeline frozen; FSM and counter keep their values.
            ctl = CTL_ALL_STALL;
        end else if (state_q == ST_HOLD) begin
            ctl = CTL_HOLD;
            if (!instr_cache_rep_active_i) begin
                state_d = ST_REDIRECT;
            end
        end else if (state_q == ST_REDIRECT) begin
            ctl     = CTL_REDIRECT;
            state_d = ST_RUN;
        end else if (instr_miss_f_i) begin
            if (mispredict) begin
                // Kill the wrong-path Decode now; fetch the new PC either
                // immediately or once the refill can no longer be disturbed.
                ctl     = CTL_HOLD;
                state_d = instr_cache_rep_active_i ? ST_HOLD : ST_REDIRECT;
            end else begin
                ctl = CTL_ALL_STALL;
            end
        end else if (ex_busy_e_i) begin
            ctl = CTL_EX_BUSY;
        end else if (mispredict) begin
            // The stalled consumer is being squashed, so its pending
            // load-use bubbles are no longer needed.
            ctl      = CTL_MISPRED;
            ld_cnt_d = '0;
        end else if (ld_cnt_q != '0) begin
            ctl      = CTL_LOAD_USE;
            ld_cnt_d = ld_cnt_q - LD_CNT_ONE;
        end else if (load_use) begin
            ctl      = CTL_LOAD_USE;
            ld_cnt_d = LD_CNT_INIT;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q            <= ST_RUN;
            ld_cnt_q           <= '0;
            redirect_pending_o <= 1'b0;
        end else begin
            state_q            <= state_d;
            ld_cnt_q           <= ld_cnt_d;
            redirect_pending_o <= (state_d != ST_RUN);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: forced inactive for the whole time reset is asserted.
    // -------------------------------------------------------------------------
    assign ctl_out       = reset_i ? CTL_NONE : ctl;
    assign forward_a_e_o = reset_i ? FWD_NONE : fwd_a;
    assign forward_b_e_o = reset_i ? FWD_NONE : fwd_b;

    assign stall_f_o = ctl_out.stall_f;
    assign stall_d_o = ctl_out.stall_d;
    assign stall_e_o = ctl_out.stall_e;
    assign stall_m_o = ctl_out.stall_m;
    assign stall_w_o = ctl_out.stall_w;
    assign flush_d_o = ctl_out.flush_d;
    assign flush_e_o = ctl_out.flush_e;
    assign flush_m_o = ctl_out.flush_m;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl with LOAD_USE_STALL = 3. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Control outputs are compared as one 8-bit vector in the order
// {stall_f,d,e,m,w, flush_d,e,m}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    // Expected control patterns, {stall_f,d,e,m,w, flush_d,e,m}.
    localparam logic [7:0] E_NONE  = 8'b00000_000;
    localparam logic [7:0] E_ALL   = 8'b11111_000;
    localparam logic [7:0] E_HOLD  = 8'b11111_100;
    localparam logic [7:0] E_REDIR = 8'b01111_110;
    localparam logic [7:0] E_BUSY  = 8'b11100_001;
    localparam logic [7:0] E_MISP  = 8'b00000_110;
    localparam logic [7:0] E_LU    = 8'b11000_010;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       instr_miss, rep_active, data_miss, ex_busy;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [2:0] result_src;
    logic [1:0] pc_src;
    logic       reg_write_m, reg_write_w;

    logic       stall_f, stall_d, stall_e, stall_m, stall_w;
    logic       flush_d, flush_e, flush_m;
    logic [1:0] fwd_a, fwd_b;
    logic       pend;
    logic [7:0] ctl_obs;

    int n_tests;
    int n_fail;

    assign ctl_obs = {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_m};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W     (5),
        .LOAD_USE_STALL (3)
    ) dut (
        .clk_i                    (clk),
        .reset_i                  (reset_i),
        .instr_miss_f_i           (instr_miss),
        .instr_cache_rep_active_i (rep_active),
        .data_miss_m_i            (data_miss),
        .ex_busy_e_i              (ex_busy),
        .rs1_d_i                  (rs1_d),
        .rs2_d_i                  (rs2_d),
        .rs1_e_i                  (rs1_e),
        .rs2_e_i                  (rs2_e),
        .rd_e_i                   (rd_e),
        .rd_m_i                   (rd_m),
        .rd_w_i                   (rd_w),
        .result_src_e_i           (result_src),
        .pc_src_i                 (pc_src),
        .reg_write_m_i            (reg_write_m),
        .reg_write_w_i            (reg_write_w),
        .stall_f_o                (stall_f),
        .stall_d_o                (stall_d),
        .stall_e_o                (stall_e),
        .stall_m_o                (stall_m),
        .stall_w_o                (stall_w),
        .flush_d_o                (flush_d),
        .flush_e_o                (flush_e),
        .flush_m_o                (flush_m),
        .forward_a_e_o            (fwd_a),
        .forward_b_e_o            (fwd_b),
        .redirect_pending_o       (pend)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // All hazard inputs inactive; reset is left untouched.
    task automatic idle();
        instr_miss  = 1'b0;
        rep_active  = 1'b0;
        data_miss   = 1'b0;
        ex_busy     = 1'b0;
        rs1_d       = '0;
        rs2_d       = '0;
        rs1_e       = '0;
        rs2_e       = '0;
        rd_e        = '0;
        rd_m        = '0;
        rd_w        = '0;
        result_src  = '0;
        pc_src      = '0;
        reg_write_m = 1'b0;
        reg_write_w = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Sample the current cycle, compare controls and redirect_pending, then
    // move to the next cycle's drive point.
    task automatic cyc(input string tag, input logic [7:0] exp_ctl, input logic exp_pend);
        @(negedge clk);
        check({tag, " ctl"}, ctl_obs, exp_ctl);
        check({tag, " pend"}, {7'd0, pend}, {7'd0, exp_pend});
        adv();
    endtask

    // Forwarding rule with both write enables set.
    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] dm,
                                           input logic [4:0] dw);
        if (rs == 5'd0) return 2'b00;
        if (rs == dm)   return 2'b10;
        if (rs == dw)   return 2'b01;
        return 2'b00;
    endfunction

    // Two write-back scenarios: distinct destinations, then a shared one
    // where Memory must win.
    task automatic sweep(input logic [4:0] dm, input logic [4:0] dw);
        rd_m = dm; rd_w = dw; reg_write_m = 1'b1; reg_write_w = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1_e = 5'(i);
            rs2_e = 5'(31 - i);
            @(negedge clk);
            check($sformatf("fwd_a m%0d w%0d rs%0d", dm, dw, i), {6'd0, fwd_a},
                  {6'd0, fwd_ref(5'(i), dm, dw)});
            check($sformatf("fwd_b m%0d w%0d rs%0d", dm, dw, 31 - i), {6'd0, fwd_b},
                  {6'd0, fwd_ref(5'(31 - i), dm, dw)});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // ---------------- reset overrides every active input ----------------
        idle();
        reset_i     = 1'b1;
        instr_miss  = 1'b1; data_miss = 1'b1; ex_busy = 1'b1; pc_src = 2'b11;
        result_src  = 3'b100; rd_e = 5'd3; rs1_d = 5'd3;
        rs1_e = 5'd3; rd_m = 5'd3; reg_write_m = 1'b1;
        rs2_e = 5'd4; rd_w = 5'd4; reg_write_w = 1'b1;
        @(negedge clk);
        check("reset ctl", ctl_obs, E_NONE);
        check("reset fwd_a", {6'd0, fwd_a}, 8'd0);
        check("reset fwd_b", {6'd0, fwd_b}, 8'd0);
        adv();
        @(negedge clk);
        check("reset pend", {7'd0, pend}, 8'd0);
        adv();
        idle();
        reset_i = 1'b0;
        cyc("idle", E_NONE, 1'b0);

        // ---------------- forwarding ----------------
        sweep(5'd5, 5'd9);
        sweep(5'd12, 5'd12);
        // Memory match without its write enable falls back to Writeback.
        rs1_e = 5'd6; rs2_e = 5'd6; rd_m = 5'd6; rd_w = 5'd6;
        reg_write_m = 1'b0; reg_write_w = 1'b1;
        @(negedge clk);
        check("fwd_a wb only", {6'd0, fwd_a}, 8'd1);
        check("fwd_b wb only", {6'd0, fwd_b}, 8'd1);
        // Register 0 is never forwarded even if both stages write it.
        rs1_e = 5'd0; rs2_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        reg_write_m = 1'b1; reg_write_w = 1'b1;
        @(negedge clk);
        check("fwd_a x0", {6'd0, fwd_a}, 8'd0);
        check("fwd_b x0", {6'd0, fwd_b}, 8'd0);
        adv();

        // ---------------- load-use: exactly three bubble cycles ----------------
        idle(); result_src = 3'b100; rd_e = 5'd5; rs1_d = 5'd5;
        cyc("lu c1", E_LU, 1'b0);
        idle();
        cyc("lu c2", E_LU, 1'b0);
        cyc("lu c3", E_LU, 1'b0);
        cyc("lu done", E_NONE, 1'b0);

        // rs2 match, then a mispredict clears the remaining bubbles.
        idle(); result_src = 3'b100; rd_e = 5'd7; rs2_d = 5'd7;
        cyc("lu rs2", E_LU, 1'b0);
        idle(); pc_src = 2'b10;
        cyc("lu misp", E_MISP, 1'b0);
        idle();
        cyc("lu cleared", E_NONE, 1'b0);

        // No hazard on x0 or on a non-load.
        idle(); result_src = 3'b100; rd_e = 5'd0; rs1_d = 5'd0;
        cyc("lu x0", E_NONE, 1'b0);
        idle(); result_src = 3'b011; rd_e = 5'd7; rs2_d = 5'd7;
        cyc("lu nonload", E_NONE, 1'b0);

        // D-cache miss freezes the bubble counter.
        idle(); result_src = 3'b100; rd_e = 5'd4; rs1_d = 5'd4;
        cyc("lu dm c1", E_LU, 1'b0);
        idle(); data_miss = 1'b1;
        cyc("lu dm frz", E_ALL, 1'b0);
        idle();
        cyc("lu dm c2", E_LU, 1'b0);
        cyc("lu dm c3", E_LU, 1'b0);
        cyc("lu dm done", E_NONE, 1'b0);

        // ---------------- Execute busy ----------------
        idle(); ex_busy = 1'b1;
        cyc("busy", E_BUSY, 1'b0);
        idle(); ex_busy = 1'b1; pc_src = 2'b10; result_src = 3'b100; rd_e = 5'd8; rs1_d = 5'd8;
        cyc("busy misp lu", E_BUSY, 1'b0);
        idle();
        cyc("busy after", E_NONE, 1'b0);

        // ---------------- mispredict in RUN ----------------
        idle(); pc_src = 2'b10;
        cyc("misp", E_MISP, 1'b0);
        idle(); pc_src = 2'b01;
        cyc("pc_src bit0", E_NONE, 1'b0);

        // ---------------- D-cache miss in RUN ----------------
        idle(); data_miss = 1'b1; instr_miss = 1'b1; pc_src = 2'b11;
        cyc("dmiss run", E_ALL, 1'b0);
        idle();
        cyc("dmiss after", E_NONE, 1'b0);

        // ---------------- I-cache miss ----------------
        idle(); instr_miss = 1'b1;
        cyc("imiss", E_ALL, 1'b0);
        idle(); instr_miss = 1'b1; ex_busy = 1'b1; pc_src = 2'b11;
        cyc("imiss busy", E_ALL, 1'b0);
        idle();
        cyc("imiss busy after", E_NONE, 1'b0);

        // Miss + mispredict, no refill: one REDIRECT cycle then RUN.
        idle(); instr_miss = 1'b1; pc_src = 2'b11;
        cyc("mr c1", E_HOLD, 1'b0);
        idle();
        cyc("mr redirect", E_REDIR, 1'b1);
        cyc("mr run", E_NONE, 1'b0);

        // Miss + mispredict with refill: five HOLD cycles, then REDIRECT.
        idle(); instr_miss = 1'b1; rep_active = 1'b1; pc_src = 2'b11;
        cyc("hold entry", E_HOLD, 1'b0);
        idle(); rep_active = 1'b1;
        cyc("hold 1", E_HOLD, 1'b1);
        idle(); rep_active = 1'b1; instr_miss = 1'b1; pc_src = 2'b10;
        cyc("hold 2", E_HOLD, 1'b1);
        idle(); rep_active = 1'b1;
        cyc("hold 3", E_HOLD, 1'b1);
        cyc("hold 4", E_HOLD, 1'b1);
        idle();
        cyc("hold 5", E_HOLD, 1'b1);
        cyc("hold redirect", E_REDIR, 1'b1);
        cyc("hold run", E_NONE, 1'b0);

        // D-cache miss inside HOLD freezes the FSM even with the refill done.
        idle(); instr_miss = 1'b1; rep_active = 1'b1; pc_src = 2'b10;
        cyc("dh entry", E_HOLD, 1'b0);
        idle(); rep_active = 1'b1;
        cyc("dh hold", E_HOLD, 1'b1);
        idle(); data_miss = 1'b1;
        cyc("dh frz 1", E_ALL, 1'b1);
        cyc("dh frz 2", E_ALL, 1'b1);
        idle(); rep_active = 1'b1;
        cyc("dh still hold", E_HOLD, 1'b1);
        idle();
        cyc("dh last hold", E_HOLD, 1'b1);

        // ---------------- reset during REDIRECT ----------------
        @(negedge clk);
        check("rr redirect ctl", ctl_obs, E_REDIR);
        reset_i = 1'b1;
        instr_miss = 1'b1; pc_src = 2'b11;
        rs1_e = 5'd2; rd_m = 5'd2; reg_write_m = 1'b1;
        #1;
        check("rr reset ctl", ctl_obs, E_NONE);
        check("rr reset fwd_a", {6'd0, fwd_a}, 8'd0);
        adv();
        idle();
        reset_i = 1'b0;
        cyc("rr run 1", E_NONE, 1'b0);
        cyc("rr run 2", E_NONE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
